datapath_sequencer: RTL
=======================

// Module: datapath_sequencer
// PURPOSE
//  Multi-cycle controller that drives the control inputs of the integer datapath:
//  register file, S-mux and 16-bit ALU.
//  Accepts one command per valid/ready handshake and issues 1..15 back-to-back ALU
//  write-back cycles (iterated add, shift-by-N, increment-by-N).
//  Latches the final N/Z/C flags and pulses done.
//  Sits between the front-panel/command source and the datapath control pins.
// PARAMETERS
//  CNT_W  4  width of repeat count (max iterations = 2**CNT_W-1)
//  ADR_W  3  register address width (8 registers)
//  OP_W   4  ALU opcode width
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      synchronous, active-high; sampled on clk rising edge
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      sequencer can accept (high only in IDLE)
//  cmd_alu_op   in   OP_W   ALU opcode for every iteration
//  cmd_w_adr    in   ADR_W  destination register
//  cmd_r_adr    in   ADR_W  R operand register (held for all iterations)
//  cmd_s_adr    in   ADR_W  S operand register, first iteration only
//  cmd_s_sel    in   1      1 = S operand from DS on first iteration
//  cmd_count    in   CNT_W  iteration count; 0 treated as 1
//  dp_we        out  1      datapath register-file write enable
//  dp_w_adr     out  ADR_W  to datapath W_Adr
//  dp_r_adr     out  ADR_W  to datapath R_Adr
//  dp_s_adr     out  ADR_W  to datapath S_Adr
//  dp_s_sel     out  1      to datapath S_Sel
//  dp_alu_op    out  OP_W   to datapath Alu_Op
//  dp_n, dp_z, dp_c  in  1 each  live ALU flags from the datapath
//  busy         out  1      high in EXEC and DONE
//  done         out  1      one-cycle pulse after the last write-back
//  flag_n, flag_z, flag_c  out  1 each  flags captured at the last iteration
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; busy=0; done=0; dp_we=0; flag_*=0; dp_* addr/op/sel=0.
//  States: IDLE -> EXEC on (cmd_valid & cmd_ready).
//   EXEC -> EXEC while remaining>1; EXEC -> DONE when remaining==1.
//   DONE -> IDLE unconditionally.
//  Accept edge: latch all cmd_* fields; remaining = (cmd_count==0) ? 1 : cmd_count.
//  dp_* outputs are decoded from state and the latched command register.
//   No combinational path from cmd_* to dp_*.
//  EXEC, first cycle: dp_we=1; dp_w/r/s_adr = latched w/r/s; dp_s_sel = latched s_sel.
//  EXEC, later cycles: dp_s_adr = latched w_adr, dp_s_sel = 0 (feedback of the previous
//   result); w/r/op unchanged.
//  Each EXEC edge writes the ALU result; remaining decrements by 1.
//  On the final EXEC edge: flag_n/z/c <= dp_n/z/c. Flags hold until the next final edge.
//  DONE: dp_we=0, done=1 for exactly one cycle. Next command is accepted no earlier than
//   the cycle after DONE.
//  Latency: accept edge -> done high = count+1 cycles (count=0 => 2).
//  cmd_valid while busy: ignored, not queued. Bench/source must hold valid until ready.
//  Reset during EXEC/DONE: the next edge forces IDLE and dp_we=0; done is not pulsed and
//   flags clear. A write in the reset cycle itself is harmless; the register file also
//   resets.
//  Opcode is passed through unchecked; undefined opcodes behave as the ALU default
//   (pass S).
//  ALU codes: 0 PASS_S, 1 PASS_R, 2 INC, 3 DEC, 4 ADD, 5 SUB, 6 SHR, 7 SHL, 8 AND, 9 OR,
//   A XOR, B NOT, C NEG.
// STRUCTURE
//  Package idp_pkg: ALU opcode localparams above, state encoding (IDLE/EXEC/DONE),
//   ADR_W/OP_W defaults.
//  One sub-module: seq_repeat_counter.
//   Loadable down-counter with a zero-substitute load and a last flag (remaining==1).
//  FSM, command register and flag register live in the top level.
// TESTING
//  1 reset high 2 cycles -> cmd_ready=1, busy=0, done=0, dp_we=0, flag_*=0.
//  2 DS=0005, cmd{PASS_S,w=1,s_sel=1,count=1} -> one dp_we cycle, w_adr=1; done 2 cycles
//    after accept; R1=0005; NZC=000.
//  3 R2=0003; cmd{ADD,r=1,s=2,w=2,count=3} -> 3 write cycles, R2 = 0008, 000D, 0012;
//    done at +4; NZC=000.
//  4 R3=4001; cmd{SHL,r=3,s=3,w=3,count=2} -> R3=8002, then 0004; flags N=0 Z=0 C=1.
//  5 count=0 with INC on R4=FFFF -> exactly 1 write, R4=0000, Z=1 C=1.
//    cmd_valid held high through busy -> accepted once only.
//  6 cmd{INC,count=8}; assert reset during 2nd EXEC -> next cycle IDLE, dp_we=0,
//    done never pulses, flags 0.

Source files
------------

// File: rtl/idp_pkg.sv
// Shared definitions for the integer datapath controller: ALU opcodes,
// default field widths and the sequencer state encoding.
package idp_pkg;

  // Default field widths of the datapath control interface.
  localparam int IDP_CNT_W = 4;
  localparam int IDP_ADR_W = 3;
  localparam int IDP_OP_W  = 4;

  // ALU opcodes. Codes D..F are undefined and behave as PASS_S in the ALU.
  localparam logic [IDP_OP_W-1:0] ALU_PASS_S = 4'h0;
  localparam logic [IDP_OP_W-1:0] ALU_PASS_R = 4'h1;
  localparam logic [IDP_OP_W-1:0] ALU_INC    = 4'h2;
  localparam logic [IDP_OP_W-1:0] ALU_DEC    = 4'h3;
  localparam logic [IDP_OP_W-1:0] ALU_ADD    = 4'h4;
  localparam logic [IDP_OP_W-1:0] ALU_SUB    = 4'h5;
  localparam logic [IDP_OP_W-1:0] ALU_SHR    = 4'h6;
  localparam logic [IDP_OP_W-1:0] ALU_SHL    = 4'h7;
  localparam logic [IDP_OP_W-1:0] ALU_AND    = 4'h8;
  localparam logic [IDP_OP_W-1:0] ALU_OR     = 4'h9;
  localparam logic [IDP_OP_W-1:0] ALU_XOR    = 4'hA;
  localparam logic [IDP_OP_W-1:0] ALU_NOT    = 4'hB;
  localparam logic [IDP_OP_W-1:0] ALU_NEG    = 4'hC;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Datapath control bundle driven by the sequencer, grouped so the
  // output decode can build it in one place.
  typedef struct packed {
    logic                we;
    logic [IDP_ADR_W-1:0] w_adr;
    logic [IDP_ADR_W-1:0] r_adr;
    logic [IDP_ADR_W-1:0] s_adr;
    logic                s_sel;
    logic [IDP_OP_W-1:0]  alu_op;
  } dp_ctrl_t;

  // All-idle control word: no write, all selects and opcode at zero.
  localparam dp_ctrl_t DP_CTRL_IDLE = '0;

endpackage : idp_pkg

// File: rtl/seq_repeat_counter.sv
// Loadable iteration down-counter. A load of zero is replaced by one so
// every accepted command performs at least one write-back; 'last' marks
// the final iteration (remaining == 1).
module seq_repeat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] remaining_q;
  logic [CNT_W-1:0] remaining_d;

  // Next-count: load wins over decrement; never wraps below zero.
  always_comb begin
    // NOTE: default assignment first so every path assigns remaining_d and no latch is inferred.
    remaining_d = remaining_q;
    if (load) begin
      remaining_d = (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (dec && (remaining_q != '0)) begin
      remaining_d = remaining_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
    if (reset) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign last = (remaining_q == CNT_W'(1));

endmodule : seq_repeat_counter

// File: rtl/datapath_sequencer.sv
// Multi-cycle controller for the integer datapath. Accepts one command per
// valid/ready handshake, issues 1..2**CNT_W-1 back-to-back ALU write-backs,
// captures the final N/Z/C flags and pulses done for one cycle.
module datapath_sequencer
  import idp_pkg::*;
#(
  parameter int CNT_W = IDP_CNT_W,
  parameter int ADR_W = IDP_ADR_W,
  parameter int OP_W  = IDP_OP_W
) (
  input  logic             clk,
  input  logic             reset,
  // Command interface
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_alu_op,
  input  logic [ADR_W-1:0] cmd_w_adr,
  input  logic [ADR_W-1:0] cmd_r_adr,
  input  logic [ADR_W-1:0] cmd_s_adr,
  input  logic             cmd_s_sel,
  input  logic [CNT_W-1:0] cmd_count,
  // Datapath control pins
  output logic             dp_we,
  output logic [ADR_W-1:0] dp_w_adr,
  output logic [ADR_W-1:0] dp_r_adr,
  output logic [ADR_W-1:0] dp_s_adr,
  output logic             dp_s_sel,
  output logic [OP_W-1:0]  dp_alu_op,
  // Live ALU flags from the datapath
  input  logic             dp_n,
  input  logic             dp_z,
  input  logic             dp_c,
  // Status
  output logic             busy,
  output logic             done,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c
);

  seq_state_e state_q, state_d;

  // Latched command fields, held for the whole command.
  logic [OP_W-1:0]  op_q,    op_d;
  logic [ADR_W-1:0] w_adr_q, w_adr_d;
  logic [ADR_W-1:0] r_adr_q, r_adr_d;
  logic [ADR_W-1:0] s_adr_q, s_adr_d;
  logic             s_sel_q, s_sel_d;
  // High during the first EXEC cycle, when S comes from the command.
  logic             first_q, first_d;

  // Captured flags of the last iteration.
  logic [2:0]       flags_q, flags_d;

  logic             accept;
  logic             last_iter;
  logic             exec_step;

  assign accept    = cmd_valid && cmd_ready;
  assign exec_step = (state_q == ST_EXEC);

  seq_repeat_counter #(
    .CNT_W (CNT_W)
  ) u_repeat (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (cmd_count),
    .dec      (exec_step),
    .last     (last_iter)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC: if (last_iter) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Output decode: datapath controls come only from state and latched
  // command, so there is no combinational path from cmd_* to dp_*.
  always_comb begin
    dp_ctrl_t ctrl;
    ctrl      = DP_CTRL_IDLE;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
      end
      ST_EXEC: begin
        busy         = 1'b1;
        ctrl.we      = 1'b1;
        ctrl.w_adr   = w_adr_q;
        ctrl.r_adr   = r_adr_q;
        ctrl.alu_op  = op_q;
        // After the first write-back the previous result is fed back on S.
        ctrl.s_adr   = first_q ? s_adr_q : w_adr_q;
        ctrl.s_sel   = first_q & s_sel_q;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
    dp_we     = ctrl.we;
    dp_w_adr  = ctrl.w_adr;
    dp_r_adr  = ctrl.r_adr;
    dp_s_adr  = ctrl.s_adr;
    dp_s_sel  = ctrl.s_sel;
    dp_alu_op = ctrl.alu_op;
  end

  // Command-register and flag next values.
  always_comb begin
    op_d    = op_q;
    w_adr_d = w_adr_q;
    r_adr_d = r_adr_q;
    s_adr_d = s_adr_q;
    s_sel_d = s_sel_q;
    first_d = first_q;
    flags_d = flags_q;
    if (accept) begin
      op_d    = cmd_alu_op;
      w_adr_d = cmd_w_adr;
      r_adr_d = cmd_r_adr;
      s_adr_d = cmd_s_adr;
      s_sel_d = cmd_s_sel;
      first_d = 1'b1;
    end else if (exec_step) begin
      first_d = 1'b0;
    end
    if (exec_step && last_iter) begin
      flags_d = {dp_n, dp_z, dp_c};
    end
  end

  // Command and flag registers.
  always_ff @(posedge clk) begin
    // NOTE: the command register is reset too so dp_* and flags read as zero straight after reset.
    if (reset) begin
      op_q    <= '0;
      w_adr_q <= '0;
      r_adr_q <= '0;
      s_adr_q <= '0;
      s_sel_q <= 1'b0;
      first_q <= 1'b0;
      flags_q <= '0;
    end else begin
      op_q    <= op_d;
      w_adr_q <= w_adr_d;
      r_adr_q <= r_adr_d;
      s_adr_q <= s_adr_d;
      s_sel_q <= s_sel_d;
      first_q <= first_d;
      flags_q <= flags_d;
    end
  end

  assign {flag_n, flag_z, flag_c} = flags_q;

endmodule : datapath_sequencer
